mem_stage_seq: RTL and testbench

- MEM-stage requester feeding the memory arbiter's MEM port.
- Accepts one word-level load/store (byte, half or word) from the MEM stage.
- Serialises it into little-endian byte accesses on the 8-bit RAM path (mem_request/addr/we/data) and reassembles load bytes into a sign- or zero-extended 32-bit result.
- The arbiter gives the MEM port priority, so every cycle this block asserts mem_request_o is a granted RAM access.

---
 rtl/mem_stage_seq_pkg.sv | 29 ++
 rtl/mem_load_ext.sv | 24 ++
 rtl/mem_stage_seq.sv | 150 +++++++++++++++
 tb/tb_mem_stage_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_seq_pkg.sv
// mem_defs: shared definitions for the MEM-stage byte-serial requester.
//   SIZE_B/SIZE_H/SIZE_W : req_size encodings (3 behaves as word)
//   state_t              : sequencer states
//   byte_count()         : req_size -> number of bytes (1, 2 or 4)
//   RAM_BYTE_W           : width of the RAM data path
package mem_defs;

  localparam int unsigned RAM_BYTE_W = 8;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: extends little-endian assembled load bytes to 32 bits.
//   raw       : assembled bytes, byte 0 in [7:0]
//   size      : SIZE_B / SIZE_H / word (any other value)
//   is_signed : sign-extend from the top loaded bit when set
//   ext       : extended result
module mem_load_ext
  import mem_defs::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SIZE_B:  ext = {{24{is_signed & raw[7]}}, raw[7:0]};
      SIZE_H:  ext = {{16{is_signed & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_seq.sv
// mem_stage_seq: MEM-stage requester on the arbiter's MEM port.
// Serialises one byte/half/word load or store into little-endian byte
// accesses on the 8-bit RAM path and reassembles load bytes.
//   clk, rst (sync, active-high), rdy (0 freezes everything)
//   req_*   : request from the MEM stage (valid/ready handshake)
//   resp_*  : one-cycle completion pulse with extended load data
//   mem_*_o : byte access to the arbiter; mem_din_i is the read byte,
//             valid the cycle after its address
module mem_stage_seq
  import mem_defs::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  mem_request_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_write_enable_o,
  output logic [RAM_BYTE_W-1:0] mem_data_o,
  input  logic [RAM_BYTE_W-1:0] mem_din_i
);

  state_t              state;
  logic [1:0]          cnt;
  logic [2:0]          n_q;
  logic                we_q;
  logic                signed_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   cap_q;

  logic                last;
  logic [1:0]          nidx;
  logic [1:0]          pidx;
  logic [DATA_W-1:0]   raw_full;
  logic [DATA_W-1:0]   ext_data;

  assign req_ready = (state == IDLE);
  assign last      = ({1'b0, cnt} == (n_q - 3'd1));
  assign nidx      = cnt + 2'd1;
  assign pidx      = cnt - 2'd1;

  // The final load byte arrives in DRAIN; merge it combinationally so the
  // extended result can be registered straight into resp_rdata.
  always_comb begin
    raw_full = cap_q;
    case (n_q)
      3'd1:    raw_full[7:0]   = mem_din_i;
      3'd2:    raw_full[15:8]  = mem_din_i;
      default: raw_full[31:24] = mem_din_i;
    endcase
  end

  mem_load_ext u_ext (
    .raw       (raw_full),
    .size      (size_q),
    .is_signed (signed_q),
    .ext       (ext_data)
  );

  // Bus outputs are registered one step ahead: the edge entering a given
  // ACCESS cycle loads that cycle's address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      n_q                <= '0;
      we_q               <= 1'b0;
      signed_q           <= 1'b0;
      size_q             <= '0;
      base_q             <= '0;
      wdata_q            <= '0;
      cap_q              <= '0;
      resp_valid         <= 1'b0;
      resp_rdata         <= '0;
      mem_request_o      <= 1'b0;
      mem_addr_o         <= '0;
      mem_write_enable_o <= 1'b0;
      mem_data_o         <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            we_q               <= req_we;
            signed_q           <= req_signed;
            size_q             <= req_size;
            n_q                <= byte_count(req_size);
            base_q             <= req_addr;
            wdata_q            <= req_wdata;
            cap_q              <= '0;
            cnt                <= '0;
            mem_request_o      <= 1'b1;
            mem_addr_o         <= req_addr;
            mem_write_enable_o <= req_we;
            mem_data_o         <= req_we ? req_wdata[7:0] : '0;
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          // Read byte for address k-1 is on mem_din_i during cycle k.
          if (!we_q && cnt != 2'd0)
            cap_q[{pidx, 3'b000} +: RAM_BYTE_W] <= mem_din_i;
          if (last) begin
            cnt                <= '0;
            mem_request_o      <= 1'b0;
            mem_addr_o         <= '0;
            mem_write_enable_o <= 1'b0;
            mem_data_o         <= '0;
            if (we_q) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              state      <= DONE;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt        <= nidx;
            mem_addr_o <= base_q + ADDR_W'(nidx);
            mem_data_o <= we_q ? wdata_q[{nidx, 3'b000} +: RAM_BYTE_W] : '0;
          end
        end
        DRAIN: begin
          cap_q      <= raw_full;
          resp_rdata <= ext_data;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_seq.sv
module tb_mem_stage_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_request_o;
  logic [31:0] mem_addr_o;
  logic        mem_write_enable_o;
  logic [7:0]  mem_data_o;
  logic [7:0]  mem_din_i = '0;

  mem_stage_seq #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_we             (req_we),
    .req_size           (req_size),
    .req_signed         (req_signed),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_rdata         (resp_rdata),
    .mem_request_o      (mem_request_o),
    .mem_addr_o         (mem_addr_o),
    .mem_write_enable_o (mem_write_enable_o),
    .mem_data_o         (mem_data_o),
    .mem_din_i          (mem_din_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (bound expired) @%0t", nm, $time);
  endtask

  // Memories are indexed by the low 16 address bits; the address pools
  // used below never alias within that window.
  logic [7:0] env_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  function automatic logic [7:0] def_byte(input int i);
    logic [31:0] a;
    a = i;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    env_mem[a[15:0]] = d;
    ref_mem[a[15:0]] = d;
  endtask

  // RAM model: one-cycle read latency, frozen by rdy, inert under rst.
  always @(posedge clk) begin
    if (rdy && !rst && mem_request_o) begin
      if (mem_write_enable_o) env_mem[mem_addr_o[15:0]] <= mem_data_o;
      else                    mem_din_i <= env_mem[mem_addr_o[15:0]];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  data;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } resp_t;

  bus_t  bus_q[$];
  resp_t resp_q[$];

  // Monitor state: previous-cycle DUT outputs and transaction timing.
  logic        p_req = 1'b0, p_we = 1'b0, p_resp = 1'b0, p_ready = 1'b0;
  logic [31:0] p_addr = '0;
  logic [7:0]  p_data = '0;
  int          n_done = 0;
  int          resp_hi = 0;
  int          since = 0;
  int          wall = 0;
  int          last_wall = 0;
  bit          in_flight = 0;
  bus_t        mb;
  resp_t       mr;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus_q.delete();
      resp_q.delete();
      in_flight = 0;
    end else begin
      if (in_flight) wall++;
      if (rdy) begin
        if (p_req) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_mem_request", p_req, 1'b0);
          end else begin
            mb = bus_q.pop_front();
            chk("bus_access", {p_addr, p_we, p_data}, {mb.addr, mb.we, mb.data});
          end
        end else begin
          chk("bus_idle_zero", {p_addr, p_we, p_data}, '0);
        end
        if (in_flight) since++;
        if (p_ready && req_valid) begin
          in_flight = 1;
          since = 0;
          wall = 0;
        end
      end
      if (resp_valid && !p_resp) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp_valid", resp_valid, 1'b0);
        end else begin
          mr = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, mr.rdata);
          chk("resp_latency", since, mr.lat);
        end
        last_wall = wall;
        in_flight = 0;
        n_done++;
      end
    end
    if (resp_valid) resp_hi++;
    p_req   = mem_request_o;
    p_we    = mem_write_enable_o;
    p_addr  = mem_addr_o;
    p_data  = mem_data_o;
    p_resp  = resp_valid;
    p_ready = req_ready;
  end

  function automatic logic pick_rdy(input bit rnd);
    if (rnd) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Reference: byte count from size, little-endian assembly by plain
  // arithmetic, two's-complement sign adjustment by subtraction.
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit rnd, input int stall_at);
    int          n;
    int          t;
    int          issued;
    longint      v;
    logic [31:0] ak;
    bus_t        b;
    resp_t       r;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 0;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      b.addr = ak;
      b.we   = we;
      b.data = we ? wd[8*k +: 8] : 8'h00;
      bus_q.push_back(b);
      if (we) ref_mem[ak[15:0]] = wd[8*k +: 8];
      else    v = v + (longint'(ref_mem[ak[15:0]]) << (8 * k));
    end
    if (!we && sg && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    r.rdata = we ? 32'h0 : v[31:0];
    r.lat   = we ? n : n + 1;
    resp_q.push_back(r);
    issued = n_done + 1;

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    rdy        = pick_rdy(rnd);
    t = 0;
    while (!(req_ready && rdy)) begin
      if (t > 50) begin
        fail_now("accept_timeout");
        req_valid = 1'b0;
        rdy = 1'b1;
        return;
      end
      @(negedge clk);
      rdy = pick_rdy(rnd);
      t++;
    end
    t = 0;
    while (n_done < issued) begin
      @(negedge clk);
      t++;
      req_valid  = 1'b0;
      req_we     = $urandom_range(0, 1);
      req_size   = $urandom_range(0, 3);
      req_signed = $urandom_range(0, 1);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (stall_at > 0 && t >= stall_at && t < stall_at + 3) rdy = 1'b0;
      else rdy = pick_rdy(rnd);
      if (t > 200) begin
        fail_now("resp_timeout");
        break;
      end
    end
    rdy = 1'b1;
    chk("bus_queue_drained", bus_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout @%0t", $time);
    $fatal(1, "simulation watchdog");
  end

  initial begin
    int snap;
    int snap_hi;
    logic [31:0] a;
    for (int i = 0; i < 65536; i++) begin
      env_mem[i] = def_byte(i);
      ref_mem[i] = def_byte(i);
    end

    // Reset and post-reset outputs.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {resp_valid, resp_rdata, mem_request_o, mem_addr_o, mem_write_enable_o, mem_data_o},
        '0);
    chk("reset_req_ready", req_ready, 1'b1);

    // LW at 0x100.
    preload(32'h100, 8'h78);
    preload(32'h101, 8'h56);
    preload(32'h102, 8'h34);
    preload(32'h103, 8'h12);
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0);

    // LB / LBU / LH signed.
    preload(32'h20, 8'h80);
    preload(32'h21, 8'hFF);
    preload(32'h22, 8'h7F);
    do_txn(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 0, 0);
    do_txn(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 0, 0);
    do_txn(1'b0, 2'd1, 1'b1, 32'h21, 32'h0, 0, 0);

    // SH then read back the whole word (upper bytes untouched).
    do_txn(1'b1, 2'd1, 1'b0, 32'h40, 32'hDEADBEEF, 0, 0);
    do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 0);

    // LW with three frozen cycles while k=2.
    snap_hi = resp_hi;
    do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 3);
    chk("stall_wall_latency", last_wall, 8);
    @(negedge clk);
    chk("stall_single_pulse", resp_hi - snap_hi, 1);

    // Reset during k=1 of a SW: only byte 0 lands.
    a = 32'h60;
    mb.addr = a;
    mb.we   = 1'b1;
    mb.data = 8'h44;
    bus_q.push_back(mb);
    ref_mem[a[15:0]] = 8'h44;
    snap = n_done;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = a;
    req_wdata = 32'h11223344;
    rdy       = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_req_ready", req_ready, 1'b1);
    chk("rst_mid_mem_request", mem_request_o, 1'b0);
    chk("rst_mid_resp_valid", resp_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_resp", n_done, snap);
    do_txn(1'b0, 2'd2, 1'b0, a, 32'h0, 0, 0);

    // Address wrap on store and load.
    do_txn(1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344, 0, 0);
    do_txn(1'b0, 2'd2, 1'b1, 32'hFFFFFFFE, 32'h0, 0, 0);
    do_txn(1'b0, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h0, 0, 0);

    // Randomized traffic with random rdy stalls.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF8 + $urandom_range(0, 7);
      else                           a = 32'h100 + $urandom_range(0, 63);
      do_txn($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             a, $urandom, 1, 0);
    end

    repeat (4) @(negedge clk);
    chk("final_resp_queue_empty", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
